// File: rtl/apim_pkg.sv
// Shared types and constants for the APIM tile sequencer/accumulator.
// Holds the FSM encoding, default widths and macro address-field positions.
package apim_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_IN = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int DEF_ADC_PRECISION          = 8;
    localparam int DEF_CIM_INPUT_PRECISION    = 8;
    localparam int DEF_CIM_INPUT_PARALLELISM  = 4;
    localparam int DEF_CIM_OUTPUT_PARALLELISM = 8;

    localparam int ROW_GRP_BASE = 5;
    localparam int ROW_GRP_W    = 3;
    localparam int COL_SEL_BASE = 0;
    localparam int COL_SEL_W    = 2;
    localparam int MAX_TILES    = 8;

    function automatic logic tiles_ok(input logic [3:0] n);
        return (n != 4'd0) && (n <= 4'(MAX_TILES));
    endfunction

endpackage

// File: rtl/apim_lane_acc.sv
// One accumulator lane: clear, add-enable, wrap or saturate.
// Saturation and the clamp output exist only with APIM_ACC_SAT_EN.
module apim_lane_acc #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add_en,
    input  logic [IN_W-1:0]  din,
    output logic [ACC_W-1:0] acc
`ifdef APIM_ACC_SAT_EN
    ,
    output logic             clamp
`endif
);

`ifdef APIM_ACC_SAT_EN
    logic [ACC_W:0] sum;

    assign sum   = {1'b0, acc} + (ACC_W+1)'(din);
    assign clamp = add_en && sum[ACC_W];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
    end
`else
    logic [ACC_W-1:0] sum;

    assign sum = acc + ACC_W'(din);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= sum;
        end
    end
`endif

endmodule

// File: rtl/apim_tile_accum.sv
// Drives the CIM macro one row-group tile per input vector and sums ADC lanes.
// Build option APIM_ACC_SAT_EN: saturating lanes plus a sticky sat_flag port.
module apim_tile_accum
    import apim_pkg::*;
#(
    parameter int ADDR_WIDTH             = 10,
    parameter int ADC_PRECISION          = DEF_ADC_PRECISION,
    parameter int CIM_INPUT_PRECISION    = DEF_CIM_INPUT_PRECISION,
    parameter int CIM_INPUT_PARALLELISM  = DEF_CIM_INPUT_PARALLELISM,
    parameter int CIM_OUTPUT_PARALLELISM = DEF_CIM_OUTPUT_PARALLELISM,
    parameter int ACC_WIDTH              = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            num_tiles,
    input  logic [1:0]            col_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CIM_INPUT_PARALLELISM*CIM_INPUT_PRECISION-1:0] in_data,
    output logic                  cim_cs,
    output logic                  cim_web,
    output logic                  cim_cimeb,
    output logic [ADDR_WIDTH-1:0] cim_a,
    output logic [CIM_INPUT_PARALLELISM*CIM_INPUT_PRECISION-1:0] cim_in_bus,
    input  logic [CIM_OUTPUT_PARALLELISM*ADC_PRECISION-1:0] cim_out_bus,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CIM_OUTPUT_PARALLELISM*ACC_WIDTH-1:0] out_data,
    output logic                  busy
`ifdef APIM_ACC_SAT_EN
    ,
    output logic                  sat_flag
`endif
);

    localparam int NL = CIM_OUTPUT_PARALLELISM;

    state_t state;
    state_t state_nxt;

    logic [3:0] tiles_q;
    logic [1:0] col_q;
    logic [2:0] tile_q;
    logic       start_acc;
    logic       in_fire;
    logic       last;
    logic       st_wait;
    logic       st_access;
    logic       st_cap;
    logic       st_done;
    logic [ADDR_WIDTH-1:0] addr;

    assign start_acc = (state == S_IDLE) && start && tiles_ok(num_tiles);
    assign in_fire   = (state == S_WAIT_IN) && in_valid;
    assign last      = ({1'b0, tile_q} == (tiles_q - 4'd1));

    assign st_wait   = (state == S_WAIT_IN);
    assign st_cap    = (state == S_CAPTURE);
    assign st_access = (state == S_ISSUE) || st_cap;
    assign st_done   = (state == S_DONE);

    always_comb begin
        addr = '0;
        addr[ROW_GRP_BASE +: ROW_GRP_W] = tile_q;
        addr[COL_SEL_BASE +: COL_SEL_W] = col_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (start_acc) state_nxt = S_WAIT_IN;
            S_WAIT_IN: if (in_valid) state_nxt = S_ISSUE;
            S_ISSUE:   state_nxt = S_CAPTURE;
            S_CAPTURE: state_nxt = last ? S_DONE : S_WAIT_IN;
            S_DONE:    if (out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Macro controls are pure state decodes so the macro sees glitch-free levels.
    always_comb begin
        in_ready  = 1'b0;
        cim_cs    = 1'b0;
        cim_cimeb = 1'b1;
        cim_a     = '0;
        out_valid = 1'b0;
        unique case (1'b1)
            st_wait: in_ready = 1'b1;
            st_access: begin
                cim_cs    = 1'b1;
                cim_cimeb = 1'b0;
                cim_a     = addr;
            end
            st_done: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign cim_web = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            tiles_q    <= '0;
            col_q      <= '0;
            tile_q     <= '0;
            cim_in_bus <= '0;
        end else begin
            if (start_acc) begin
                tiles_q <= num_tiles;
                col_q   <= col_sel;
                tile_q  <= '0;
            end
            if (in_fire) begin
                cim_in_bus <= in_data;
            end
            if (st_cap && !last) begin
                tile_q <= tile_q + 3'd1;
            end
        end
    end

`ifdef APIM_ACC_SAT_EN
    logic [NL-1:0] clamp;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            sat_flag <= 1'b0;
        end else if (|clamp) begin
            sat_flag <= 1'b1;
        end
    end
`endif

    for (genvar i = 0; i < NL; i++) begin : g_lane
        apim_lane_acc #(
            .IN_W  (ADC_PRECISION),
            .ACC_W (ACC_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (start_acc),
            .add_en (st_cap),
            .din    (cim_out_bus[i*ADC_PRECISION +: ADC_PRECISION]),
            .acc    (out_data[i*ACC_WIDTH +: ACC_WIDTH])
`ifdef APIM_ACC_SAT_EN
            ,
            .clamp  (clamp[i])
`endif
        );
    end

endmodule

// File: doc/apim_tile_accum.md
Name: apim_tile_accum

Overview:
- Sequencer and accumulator directly downstream of the Basic_GeMM_CIM macro.
- Takes 4-lane input vectors from upstream and drives the macro in CIM mode, one row-group tile per vector (address bits a[7:5]).
- Captures the 8 ADC lanes (cim_out0..7) for each tile and accumulates them over a programmed number of tiles.
- Emits one 8-lane partial-score word through a valid/ready handshake to the score stage.

Parameters:
- ADDR_WIDTH, 10, macro address width.
- ADC_PRECISION, 8, width of each cim_out lane.
- CIM_INPUT_PRECISION, 8, width of each cim_in lane.
- CIM_INPUT_PARALLELISM, 4, number of cim_in lanes.
- CIM_OUTPUT_PARALLELISM, 8, number of cim_out lanes and accumulators.
- ACC_WIDTH, 16, width of each accumulator; must be at least ADC_PRECISION.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle command pulse; accepted only in IDLE.
- num_tiles  in  4  tiles to accumulate, 1..8; sampled with start.
- col_sel  in  2  column set; drives cim_a[1:0]; sampled with start.
- in_valid  in  1  upstream input vector valid.
- in_ready  out  1  block accepts in_data.
- in_data  in  CIM_INPUT_PARALLELISM*CIM_INPUT_PRECISION  packed cim_in0..3, lane 0 in the LSBs.
- cim_cs  out  1  macro chip select.
- cim_web  out  1  macro write enable (low active); always 1 from this block.
- cim_cimeb  out  1  macro CIM enable (low active).
- cim_a  out  ADDR_WIDTH  macro address.
- cim_in_bus  out  CIM_INPUT_PARALLELISM*CIM_INPUT_PRECISION  registered input lanes to the macro.
- cim_out_bus  in  CIM_OUTPUT_PARALLELISM*ADC_PRECISION  packed cim_out0..7, lane 0 in the LSBs.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  CIM_OUTPUT_PARALLELISM*ACC_WIDTH  packed accumulators, lane 0 in the LSBs.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE; tile counter, accumulators and the cim_in register clear to 0.
  - Outputs: out_valid=0, in_ready=0, busy=0, cim_cs=0, cim_web=1, cim_cimeb=1, cim_a=0.
  - Reset mid-operation abandons the job. No output is produced and no macro access follows.
- FSM states: IDLE, WAIT_IN, ISSUE, CAPTURE, DONE. Macro controls are decoded from the state register (Moore outputs).
- IDLE:
  - start=1 with num_tiles in 1..8 latches num_tiles and col_sel, clears the accumulators and tile counter, then moves to WAIT_IN.
  - start with num_tiles=0 or num_tiles>8 is ignored.
  - start outside IDLE is ignored.
- WAIT_IN:
  - in_ready=1.
  - On in_valid, in_data is registered into cim_in_bus and the FSM moves to ISSUE.
- ISSUE:
  - cim_cs=1, cim_web=1, cim_cimeb=0.
  - cim_a = {2'b00, tile[2:0], 3'b000, col_sel}, zero-extended to ADDR_WIDTH.
  - The macro registers its sums at the edge that ends ISSUE.
- CAPTURE:
  - Same controls and address as ISSUE, held so the macro's gated outputs stay valid.
  - At the end of CAPTURE, each lane updates acc[i] += zero-extended cim_out lane i.
  - If tile == num_tiles-1, go to DONE; otherwise increment tile and return to WAIT_IN.
- Per-tile latency: 2 cycles after input acceptance. Minimum job length: 3*num_tiles + 1 cycles to out_valid.
- DONE:
  - out_valid=1 and out_data = accumulators; both are held stable until out_ready.
  - On the out_valid&&out_ready handshake, return to IDLE with the accumulators left unchanged.
  - A start in that same cycle is ignored.
- Arithmetic: unsigned, modulo 2^ACC_WIDTH (wrap) unless the optional feature is enabled.
- cim_in_bus changes only on an accepted input. cim_web is never driven low, so the block never writes the macro.

Optional Feature:
- Macro: APIM_ACC_SAT_EN.
- Defined: each accumulator update saturates at 2^ACC_WIDTH-1. A sticky per-job flag, output port sat_flag (1 bit), is set on any lane clamp and cleared on start accept and on reset.
- Undefined: updates wrap modulo 2^ACC_WIDTH and the sat_flag port does not exist.

Decomposition:
- Shared package (apim_pkg):
  - FSM state encoding.
  - Default parameter constants: ADC_PRECISION, CIM_INPUT_PRECISION, CIM_INPUT_PARALLELISM, CIM_OUTPUT_PARALLELISM.
  - The address-field positions: row-group base 5, col-select base 0.
- One natural sub-module, apim_lane_acc:
  - A single accumulator lane with clear, add-enable and optional saturation.
  - Instantiated CIM_OUTPUT_PARALLELISM times.

Test Plan:
- Single tile: start with num_tiles=1, col_sel=2; in_data lanes = 1; macro model returns lane i = 10+i. Required: cim_a=0x002 during ISSUE/CAPTURE, out_data lanes = 10..17, out_valid asserted 4 cycles after start.
- Multi-tile: num_tiles=8, col_sel=0; macro returns 255 on all lanes. Required: cim_a[7:5] steps 0..7, every lane = 2040, exactly 8 in_ready handshakes.
- Backpressure: in_valid low for 5 cycles in WAIT_IN; out_ready low for 10 cycles in DONE. Required: no macro access while waiting; out_data stable and out_valid held high until out_ready.
- Ignored commands: start with num_tiles=0 while IDLE, then start during CAPTURE of a 3-tile job. Required: the first is ignored (busy stays 0); the job result is unaffected.
- Reset mid-job: rst during CAPTURE of tile 2. Required: next cycle IDLE, cim_cs=0, cim_cimeb=1, out_valid=0; a new job afterwards gives correct sums.
- Width stress: ACC_WIDTH=10, num_tiles=8, lanes 255. Required: without APIM_ACC_SAT_EN each lane = 2040 mod 1024 = 1016; with the macro defined each lane = 1023 and sat_flag=1.
